// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - ASCII to Morse key-line encoder
//
// Accepts one ASCII character per valid/ready handshake and keys it out as
// dot/dash marks separated by symbol, character and word gaps.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   char_i        in   ASCII character (held stable until accepted)
//   char_valid_i  in   char_i is valid
//   char_ready_o  out  encoder is idle and can accept a character
//   key_o         out  1 = key down (mark), 0 = key up
//   busy_o        out  a character or word gap is in progress
//   err_o         out  one-cycle pulse: unsupported character dropped

module morse_encoder #(
    parameter int unsigned DOT_TICKS      = 15_000_000,
    parameter int unsigned DASH_TICKS     = 60_000_000,
    parameter int unsigned SYM_GAP_TICKS  = 25_000_000,
    parameter int unsigned CHAR_GAP_TICKS = 200_000_000,
    parameter int unsigned WORD_GAP_TICKS = 100_000_000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    output logic       key_o,
    output logic       busy_o,
    output logic       err_o
);

    // Counters are loaded with N-1 so each state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_TICKS - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_TICKS - 1);
    localparam logic [CNT_W-1:0] SYM_LOAD  = CNT_W'(SYM_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(CHAR_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] WORD_LOAD = CNT_W'(WORD_GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SYM_GAP,
        S_CHAR_GAP,
        S_WORD_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_pattern;
    logic [2:0]       r_len;
    logic             r_key;
    logic             r_err;

    logic [7:0]       w_upper;
    logic [7:0]       w_lut;
    logic [4:0]       w_lut_pattern;
    logic [2:0]       w_lut_len;

    // Fold lowercase onto uppercase so the table only lists capitals.
    assign w_upper = (char_i >= 8'h61 && char_i <= 8'h7a) ? (char_i - 8'h20) : char_i;

    // {pattern[4:0], len[2:0]}; dash = 1, first symbol in bit 4.
    // len == 0 marks an unsupported character.
    always_comb begin
        w_lut = 8'h00;
        case (w_upper)
            "A": w_lut = {5'b01000, 3'd2};
            "B": w_lut = {5'b10000, 3'd4};
            "C": w_lut = {5'b10100, 3'd4};
            "D": w_lut = {5'b10000, 3'd3};
            "E": w_lut = {5'b00000, 3'd1};
            "F": w_lut = {5'b00100, 3'd4};
            "G": w_lut = {5'b11000, 3'd3};
            "H": w_lut = {5'b00000, 3'd4};
            "I": w_lut = {5'b00000, 3'd2};
            "J": w_lut = {5'b01110, 3'd4};
            "K": w_lut = {5'b10100, 3'd3};
            "L": w_lut = {5'b01000, 3'd4};
            "M": w_lut = {5'b11000, 3'd2};
            "N": w_lut = {5'b10000, 3'd2};
            "O": w_lut = {5'b11100, 3'd3};
            "P": w_lut = {5'b01100, 3'd4};
            "Q": w_lut = {5'b11010, 3'd4};
            "R": w_lut = {5'b01000, 3'd3};
            "S": w_lut = {5'b00000, 3'd3};
            "T": w_lut = {5'b10000, 3'd1};
            "U": w_lut = {5'b00100, 3'd3};
            "V": w_lut = {5'b00010, 3'd4};
            "W": w_lut = {5'b01100, 3'd3};
            "X": w_lut = {5'b10010, 3'd4};
            "Y": w_lut = {5'b10110, 3'd4};
            "Z": w_lut = {5'b11000, 3'd4};
            "0": w_lut = {5'b11111, 3'd5};
            "1": w_lut = {5'b01111, 3'd5};
            "2": w_lut = {5'b00111, 3'd5};
            "3": w_lut = {5'b00011, 3'd5};
            "4": w_lut = {5'b00001, 3'd5};
            "5": w_lut = {5'b00000, 3'd5};
            "6": w_lut = {5'b10000, 3'd5};
            "7": w_lut = {5'b11000, 3'd5};
            "8": w_lut = {5'b11100, 3'd5};
            "9": w_lut = {5'b11110, 3'd5};
            default: w_lut = 8'h00;
        endcase
    end

    assign w_lut_pattern = w_lut[7:3];
    assign w_lut_len     = w_lut[2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_key     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (char_valid_i) begin
                        if (w_lut_len != 3'd0) begin
                            r_state   <= S_MARK;
                            r_key     <= 1'b1;
                            r_pattern <= w_lut_pattern;
                            r_len     <= w_lut_len;
                            r_cnt     <= w_lut_pattern[4] ? DASH_LOAD : DOT_LOAD;
                        end else if (char_i == 8'h20) begin
                            r_state <= S_WORD_GAP;
                            r_cnt   <= WORD_LOAD;
                        end else begin
                            // Dropped without leaving IDLE, so the next
                            // character can be taken on the following cycle.
                            r_err <= 1'b1;
                        end
                    end
                end

                S_MARK: begin
                    if (r_cnt == '0) begin
                        r_key <= 1'b0;
                        r_len <= r_len - 3'd1;
                        if (r_len > 3'd1) begin
                            r_state   <= S_SYM_GAP;
                            r_cnt     <= SYM_LOAD;
                            r_pattern <= {r_pattern[3:0], 1'b0};
                        end else begin
                            r_state <= S_CHAR_GAP;
                            r_cnt   <= CHAR_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_SYM_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_MARK;
                        r_key   <= 1'b1;
                        r_cnt   <= r_pattern[4] ? DASH_LOAD : DOT_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_CHAR_GAP, S_WORD_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_key   <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready_o = (r_state == S_IDLE);
    assign busy_o       = ~char_ready_o;
    assign key_o        = r_key;
    assign err_o        = r_err;

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Transmit-side counterpart of the Morse decoder: accepts ASCII characters over a valid/ready handshake and drives a single key line (LED/buzzer/loopback into the decoder button input) with dot, dash and gap timing. The timing sits inside the decoder's classification windows (dot <0.3 s, dash 0.3–1 s, char gap 1.75–2.5 s, word gap >2.5 s) at 100 MHz. Symbol patterns use the team encoding: dot = 0, dash = 1, first-transmitted symbol in the MSB, at most `MORSE_CHAR_WIDTH_MAX_C` (5) symbols per character.

## Interface
- `DOT_TICKS`, 15_000_000: mark length of a dot, in cycles (0.15 s).
- `DASH_TICKS`, 60_000_000: mark length of a dash (0.6 s).
- `SYM_GAP_TICKS`, 25_000_000: key-low time between symbols of one character (0.25 s).
- `CHAR_GAP_TICKS`, 200_000_000: key-low time after the last symbol of a character (2.0 s).
- `WORD_GAP_TICKS`, 100_000_000: key-low time for an ASCII space (1.0 s). Added after the preceding char gap, so the total is 3.0 s.
- `CNT_W`, 29: tick counter width. Must hold the largest tick parameter. All tick parameters are ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `char_i`  in  8  ASCII character.
- `char_valid_i`  in  1  `char_i` is valid.
- `char_ready_o`  out  1  encoder can accept a character.
- `key_o`  out  1  1 = key down (mark), 0 = key up.
- `busy_o`  out  1  state ≠ IDLE.
- `err_o`  out  1  one-cycle pulse: unsupported character dropped.

## Operation
- **Supported characters**
  - 'A'–'Z' and 'a'–'z' (case-insensitive), '0'–'9': standard International Morse, 1–5 symbols.
  - 0x20 (space): word gap.
  - Anything else is unsupported.
- **Lookup**: combinational ASCII → {pattern[4:0], len[2:0]}. Pattern is left-aligned. Bits below `len` are don't-care and driven 0.
- **FSM states**: IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP.
- **IDLE**
  - `char_ready_o`=1.
  - A handshake occurs when `char_valid_i` && `char_ready_o`.
  - Letter or digit: latch pattern and len into a shift register and symbol counter, then go to MARK. Load the counter with DOT_TICKS-1 or DASH_TICKS-1 according to pattern[4].
  - Space: go to WORD_GAP and load WORD_GAP_TICKS-1.
  - Unsupported: stay in IDLE and pulse `err_o` in the next cycle. No key activity.
- **MARK**
  - `key_o`=1.
  - When the counter reaches 0, decrement the remaining-symbol count.
  - If symbols remain: go to SYM_GAP (load SYM_GAP_TICKS-1) and shift the pattern left by 1.
  - Otherwise: go to CHAR_GAP (load CHAR_GAP_TICKS-1).
- **SYM_GAP**
  - `key_o`=0.
  - At counter 0, go to MARK and load the dot or dash length from the new pattern[4].
- **CHAR_GAP and WORD_GAP**
  - `key_o`=0.
  - At counter 0, go to IDLE.
- **Registers**: `key_o` is a register equal to (state==MARK). `char_ready_o` = (state==IDLE). `busy_o` = !`char_ready_o`.
- **Backpressure**: `char_valid_i` held while busy is not consumed and `char_i` is ignored. The source must hold `char_i` stable until the handshake.
- **Reset**
  - When `rst_n`=0 at a rising edge, including mid-character, the block goes to IDLE.
  - `key_o`=0, `err_o`=0, counter, pattern and len cleared.
  - Any in-flight character is discarded and not resumed.
  - Outputs after reset: `char_ready_o`=1, `busy_o`=0, `key_o`=0, `err_o`=0.

## Timing
- **Handshake to first mark**: handshake at edge T. `key_o` rises in the cycle after T (registered, 1-cycle latency).
- **Exact state durations**
  - Each MARK lasts exactly DOT_TICKS or DASH_TICKS cycles.
  - Each SYM_GAP lasts SYM_GAP_TICKS cycles.
  - CHAR_GAP lasts CHAR_GAP_TICKS cycles and WORD_GAP lasts WORD_GAP_TICKS cycles.
  - No extra bubble cycles between states.
- **Character duration**: sum of marks + (len-1)·SYM_GAP_TICKS + CHAR_GAP_TICKS cycles.
- **Back-to-back**: `char_ready_o` returns high in the first cycle after the final gap. If valid is already high, the next handshake happens in that same cycle. Maximum throughput is one character per character-duration + 0 idle cycles.
- **Error pulse**: `err_o` is high exactly one cycle (T+1). The FSM stays ready, so an unsupported character followed by a valid one can handshake on consecutive cycles.
- **Counter rules**: the counter is a down-counter of width `CNT_W` and never wraps. A load always occurs on state entry.

## Test plan
Bench overrides: DOT=2, DASH=6, SYM_GAP=2, CHAR_GAP=6, WORD_GAP=10.
- **'A' handshake at T**: `key_o` over T+1… = 1,1,0,0,1×6,0×6. `char_ready_o` is 0 from T+1 to T+16 and 1 at T+17. `err_o` stays 0.
- **'k' (lowercase), then '5' with valid held**
  - 'k' key pattern: 1×6,0×2,1×2,0×2,1×6,0×6.
  - '5' is accepted in the first ready cycle and gives five 2-cycle marks separated by 2-cycle gaps.
- **'#' then 'E' on consecutive cycles**: `err_o`=1 for exactly one cycle, no key activity for '#'. 'E' is accepted the next cycle and gives `key_o`=1,1 then six 0s.
- **"E E" (0x45, 0x20, 0x45)**: key-low time between the two E marks is 6+10=16 cycles. `busy_o` is 1 throughout the space.
- **Reset during the dash of 'T'**: `rst_n`=0 for 1 cycle at mark cycle 3. On the next edge `key_o`=0 and `char_ready_o`=1. The dash does not resume.
- **'0' (5 dashes)**: total busy = 5·6+4·2+6 = 44 cycles. Confirms the 5-symbol maximum and that `len` does not wrap.
